// File: rtl/link_ctrl_verde.sv
// link_ctrl_verde: receive-side link controller that acquires COM lock, strips COM/IDLE fill and requests resync on persistent byte loss.
// Ports: clk_4f/reset (async, active-high); byte_in/byte_valid/sp_active from the deserializer;
// data_out/valid_out forwarded payload; link_up (LOCKED); resync_req (RESYNC cycle); state; err_count.
// Optional feature macro LINK_ERR_COUNT_EN: cumulative saturating error counter on err_count, else tied to 0.
module link_ctrl_verde #(
   parameter logic [7:0]  COM_SYM    = 8'hBC,
   parameter logic [7:0]  IDL_SYM    = 8'h7C,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned ERR_LIMIT  = 3
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       sp_active,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       link_up,
   output logic       resync_req,
   output logic [1:0] state,
   output logic [3:0] err_count
);
   typedef enum logic [1:0] {IDLE = 2'b00, SEARCH = 2'b01, LOCKED = 2'b10, RESYNC = 2'b11} state_t;
   state_t state_q, state_d;
   logic [3:0] com_cnt_q, com_cnt_d, err_run_q, err_run_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   always_comb begin
      state_d   = state_q;
      com_cnt_d = com_cnt_q;
      err_run_d = err_run_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      case (state_q)
         IDLE: if (sp_active) begin
            state_d   = SEARCH;
            com_cnt_d = '0;
         end
         SEARCH: if (byte_valid) begin
            if (byte_in != COM_SYM) com_cnt_d = '0;
            else if (com_cnt_q == 4'(LOCK_COUNT - 1)) begin
               state_d   = LOCKED;
               err_run_d = '0;
            end else com_cnt_d = com_cnt_q + 4'd1;
         end
         LOCKED: begin
            // payload is forwarded even on the edge that leaves LOCKED
            if (byte_valid) begin
               err_run_d = '0;
               if (byte_in != COM_SYM && byte_in != IDL_SYM) begin
                  data_d  = byte_in;
                  valid_d = 1'b1;
               end
            end else if (sp_active) begin
               err_run_d = (err_run_q == 4'hF) ? err_run_q : err_run_q + 4'd1;
               if (err_run_q >= 4'(ERR_LIMIT - 1)) state_d = RESYNC;
            end
         end
         default: begin
            state_d   = SEARCH;
            com_cnt_d = '0;
            err_run_d = '0;
         end
      endcase
      // losing the deserializer overrides every other transition
      if (!sp_active) state_d = IDLE;
   end
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         com_cnt_q <= '0;
         err_run_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         com_cnt_q <= com_cnt_d;
         err_run_q <= err_run_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end
`ifdef LINK_ERR_COUNT_EN
   logic [3:0] err_count_q, err_count_d;
   logic       bump;
   // error cycles in LOCKED and the single RESYNC cycle each add one
   assign bump = (state_q == LOCKED && !byte_valid && sp_active) || state_q == RESYNC;
   always_comb err_count_d = (bump && err_count_q != 4'hF) ? err_count_q + 4'd1 : err_count_q;
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) err_count_q <= '0;
      else err_count_q <= err_count_d;
   end
   assign err_count = err_count_q;
`else
   assign err_count = 4'h0;
`endif
   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign link_up    = state_q == LOCKED;
   assign resync_req = state_q == RESYNC;
   assign state      = state_q;
endmodule

// File: doc/link_ctrl_verde.md
# link_ctrl_verde

Receive-side link controller for the verde lane. It runs in the `clk_4f` domain directly after the serial-to-parallel converter and consumes its byte stream and `active` flag. It acquires symbol lock by counting consecutive COM symbols and strips COM/IDLE fill from the stream. It forwards payload bytes, monitors for missing bytes while locked, and requests a resync when errors persist.

## Interface
Parameters:
- `COM_SYM`, 8'hBC: comma/alignment symbol.
- `IDL_SYM`, 8'h7C: idle fill symbol.
- `LOCK_COUNT`, 4: consecutive COM bytes required for lock (range 1–15).
- `ERR_LIMIT`, 3: consecutive error cycles that force resync (range 1–15).

Ports:
- `clk_4f`, in, 1: byte clock; the block's only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `byte_in`, in, 8: parallel byte from the deserializer (`data2send`).
- `byte_valid`, in, 1: `byte_in` is valid this cycle (deserializer `valid_out`).
- `sp_active`, in, 1: deserializer `active` flag.
- `data_out`, out, 8: forwarded payload byte.
- `valid_out`, out, 1: `data_out` is valid.
- `link_up`, out, 1: high while in LOCKED.
- `resync_req`, out, 1: one-cycle pulse on entry to RESYNC.
- `state`, out, 2: current FSM state encoding.
- `err_count`, out, 4: cumulative error count (see Configuration).

## Operation
- FSM encoding: IDLE=2'b00, SEARCH=2'b01, LOCKED=2'b10, RESYNC=2'b11. All transitions occur on the `clk_4f` rising edge.
- IDLE:
  - Outputs quiet.
  - `sp_active`=1 → SEARCH, with `com_cnt` cleared to 0.
- SEARCH:
  - Each cycle with `byte_valid`=1 and `byte_in`==COM_SYM increments `com_cnt`.
  - A valid non-COM byte clears `com_cnt` to 0.
  - Cycles with `byte_valid`=0 hold `com_cnt`.
  - When `com_cnt`+1 reaches LOCK_COUNT on a COM byte → LOCKED. `err_run` is cleared.
- LOCKED:
  - A valid byte equal to COM_SYM or IDL_SYM is dropped and clears `err_run`.
  - Any other valid byte is registered to `data_out` with `valid_out`=1 on the next cycle, and clears `err_run`.
  - `byte_valid`=0 with `sp_active`=1 is an error cycle: it increments `err_run`.
  - When `err_run` reaches ERR_LIMIT → RESYNC.
- RESYNC:
  - Lasts exactly one cycle, with `resync_req`=1.
  - Then → SEARCH, with `com_cnt` and `err_run` cleared.
- Global rule: `sp_active`=0 in any state → IDLE at the next edge. This has priority over every other transition, including a simultaneous lock or error-limit event.
- `valid_out` is low in every state except the cycle after a forwarded byte in LOCKED. The byte accepted on the edge that leaves LOCKED is still forwarded.
- `data_out` holds its last value when `valid_out`=0.
- `com_cnt` and `err_run` are 4-bit counters. `err_run` saturates at 15 and never wraps.

## Timing
- Reset values: `state`=IDLE, `data_out`=8'h00, `valid_out`=0, `link_up`=0, `resync_req`=0, `err_count`=0, internal counters=0.
- `reset` acts asynchronously on assertion. A `reset` mid-frame clears everything immediately, with no partial output.
- Forwarding latency: `byte_in` to `data_out`/`valid_out` is 1 cycle.
- Lock: `link_up` rises on the cycle after the LOCK_COUNT-th consecutive valid COM byte.
- Loss: `link_up` falls on the edge that leaves LOCKED.
- `resync_req` is high exactly 1 cycle, on the cycle after the ERR_LIMIT-th consecutive error cycle.
- Re-acquisition after RESYNC needs another LOCK_COUNT COM bytes starting from 0.

## Configuration
- `LINK_ERR_COUNT_EN` defined:
  - `err_count` is a cumulative saturating 4-bit count of error cycles in LOCKED since reset (15 holds).
  - RESYNC entries also add 1 (saturating).
  - The count is not cleared by state changes, only by `reset`.
- Not defined: `err_count` is tied to 4'h0, and no counter logic is synthesized. The port exists in both builds, so benches are unchanged.

## Test plan
- Reset held, then released with `sp_active`=1 and four valid 8'hBC bytes:
  - `state` goes 00→01.
  - `link_up`=1 one cycle after the 4th BC; `state`=2'b10.
- Lock sequence BC,BC,BC,0x55,BC,BC,BC,BC:
  - The 0x55 clears the count.
  - `link_up` rises only after the final BC (8 bytes total).
- Locked stream BC,7C,0xA5,0x3C,7C:
  - `valid_out` pulses exactly twice, with `data_out`=0xA5 then 0x3C, each 1 cycle after its input.
- Locked, then 3 cycles with `byte_valid`=0:
  - `resync_req` is a 1-cycle pulse, `state` 11→01, `link_up`=0.
  - With `LINK_ERR_COUNT_EN`: `err_count`=4.
  - 2 invalid cycles followed by a valid byte cause no resync.
- `sp_active` dropped in the same cycle as the 4th BC or the 3rd error cycle:
  - `state` goes to IDLE, with no `link_up` and no `resync_req`.
- `reset` asserted mid-stream while `valid_out`=1:
  - All outputs are 0 immediately, before the next clock edge.
